// File: rtl/sbox_word_stage_pkg.sv
// Shared AES word-level definitions: word/byte widths, byte-lane positions and RotWord.
package sbox_word_stage_pkg;

   localparam int AES_WORD_W = 32;
   localparam int AES_BYTE_W = 8;
   localparam int N_LANES    = AES_WORD_W / AES_BYTE_W;

   // MSB position of each byte lane; lane 0 is the most significant byte of the word
   localparam int LANE_MSB [N_LANES] = '{31, 23, 15, 7};

   function automatic logic [AES_WORD_W-1:0] rotword(input logic [AES_WORD_W-1:0] w);
      return {w[AES_WORD_W-AES_BYTE_W-1:0], w[AES_WORD_W-1 -: AES_BYTE_W]};
   endfunction

endpackage

// File: rtl/sbox_forward.sv
// Forward AES S-box on one byte (u0/s0 are the MSBs), computed as GF(2^8) inverse plus affine map.
// state=1 passes the byte through unsubstituted; the word stage ties it low.
module sbox_forward (
   input  logic u0,
   input  logic u1,
   input  logic u2,
   input  logic u3,
   input  logic u4,
   input  logic u5,
   input  logic u6,
   input  logic u7,
   input  logic state,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic s4,
   output logic s5,
   output logic s6,
   output logic s7
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = x;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   logic [7:0] u;
   logic [7:0] s;

   assign u = {u0, u1, u2, u3, u4, u5, u6, u7};
   assign s = state ? u : affine(gf_inv(u));
   assign {s0, s1, s2, s3, s4, s5, s6, s7} = s;

endmodule

// File: rtl/sbox_word_stage.sv
// Elastic SubWord stage: optional RotWord, four S-boxes, then a LATENCY-deep valid/ready pipe
// carrying tag/last sideband, with flush and a wrapping handoff counter.
module sbox_word_stage
   import sbox_word_stage_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int TAG_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [AES_WORD_W-1:0] in_data,
   input  logic                  in_rot,
   input  logic [TAG_W-1:0]      in_tag,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [AES_WORD_W-1:0] out_data,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_last,
   output logic                  busy,
   output logic [CNT_W-1:0]      out_count
);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("sbox_word_stage: LATENCY must be in 1..4");
   end

   logic [LATENCY:1]      v_q, v_d, rdy;
   logic [AES_WORD_W-1:0] data_q [1:LATENCY];
   logic [AES_WORD_W-1:0] data_d [1:LATENCY];
   logic [TAG_W-1:0]      tag_q  [1:LATENCY];
   logic [TAG_W-1:0]      tag_d  [1:LATENCY];
   logic [LATENCY:1]      last_q, last_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [AES_WORD_W-1:0] rot_w, sub_w;
   logic                  accept, handoff;

   assign rot_w = in_rot ? rotword(in_data) : in_data;

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      sbox_forward u_sbox (
         .u0   (rot_w[LANE_MSB[g]]),
         .u1   (rot_w[LANE_MSB[g]-1]),
         .u2   (rot_w[LANE_MSB[g]-2]),
         .u3   (rot_w[LANE_MSB[g]-3]),
         .u4   (rot_w[LANE_MSB[g]-4]),
         .u5   (rot_w[LANE_MSB[g]-5]),
         .u6   (rot_w[LANE_MSB[g]-6]),
         .u7   (rot_w[LANE_MSB[g]-7]),
         .state(1'b0),
         .s0   (sub_w[LANE_MSB[g]]),
         .s1   (sub_w[LANE_MSB[g]-1]),
         .s2   (sub_w[LANE_MSB[g]-2]),
         .s3   (sub_w[LANE_MSB[g]-3]),
         .s4   (sub_w[LANE_MSB[g]-4]),
         .s5   (sub_w[LANE_MSB[g]-5]),
         .s6   (sub_w[LANE_MSB[g]-6]),
         .s7   (sub_w[LANE_MSB[g]-7])
      );
   end

   // A stage may load when the consumer takes the output word or any stage at or below it is empty
   always_comb begin
      rdy = '0;
      for (int i = 1; i <= LATENCY; i++) begin
         rdy[i] = out_ready;
         for (int j = i; j <= LATENCY; j++) begin
            if (!v_q[j]) rdy[i] = 1'b1;
         end
      end
   end

   assign in_ready = rdy[1] & ~flush;
   assign accept   = in_valid & in_ready;
   assign handoff  = v_q[LATENCY] & out_ready;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      tag_d  = tag_q;
      last_d = last_q;
      // stage 1: capture the substituted word
      if (rdy[1]) begin
         v_d[1] = accept;
         if (accept) begin
            data_d[1] = sub_w;
            tag_d[1]  = in_tag;
            last_d[1] = in_last;
         end
      end
      // stages 2..LATENCY: pure delay
      for (int i = 2; i <= LATENCY; i++) begin
         if (rdy[i]) begin
            v_d[i] = v_q[i-1];
            if (v_q[i-1]) begin
               data_d[i] = data_q[i-1];
               tag_d[i]  = tag_q[i-1];
               last_d[i] = last_q[i-1];
            end
         end
      end
      if (flush) v_d = '0;
      cnt_d = cnt_q + CNT_W'(handoff);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= '0;
         last_q <= '0;
         cnt_q  <= '0;
         for (int i = 1; i <= LATENCY; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         tag_q  <= tag_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = v_q[LATENCY];
   assign out_data  = data_q[LATENCY];
   assign out_tag   = tag_q[LATENCY];
   assign out_last  = last_q[LATENCY];
   assign busy      = |v_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_sbox_word_stage.sv
// Bench for sbox_word_stage: directed known-answer vectors plus a queue-based scoreboard
// that checks every output each cycle against an independently generated S-box model.
module tb_sbox_word_stage;

   localparam int L  = 2;
   localparam int TW = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, in_rot, in_last;
   logic [31:0]   in_data, out_data;
   logic [TW-1:0] in_tag, out_tag;
   logic          out_valid, out_ready, out_last, busy;
   logic [CW-1:0] out_count;

   sbox_word_stage #(.LATENCY(L), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rot(in_rot),
      .in_tag(in_tag), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_last(out_last), .busy(busy), .out_count(out_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // S-box built with the classic generator walk over powers of 3 and their inverses
   logic [7:0] sb [256];

   function automatic int rotl8(input int x, input int s);
      return ((x << s) | (x >> (8 - s))) & 8'hFF;
   endfunction

   task automatic build_sbox();
      int p, q, x;
      p = 1;
      q = 1;
      do begin
         p = (p ^ (p << 1) ^ (((p & 8'h80) != 0) ? 8'h1B : 8'h00)) & 8'hFF;
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         q = q & 8'hFF;
         if ((q & 8'h80) != 0) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sb[p] = 8'(x ^ 8'h63);
      end while (p != 1);
      sb[0] = 8'h63;
   endtask

   function automatic logic [31:0] m_subword(input logic [31:0] w, input logic rot);
      logic [31:0] x;
      x = rot ? {w[23:0], w[31:24]} : w;
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   typedef struct {
      logic [31:0]   d;
      logic [TW-1:0] t;
      logic          l;
      int            acc;
   } ent_t;

   ent_t          q[$];
   logic [CW-1:0] cnt_m = '0;
   logic          ev, mr;

   // Scoreboard: the queue holds exactly the words in flight; the oldest one is visible
   // once L-1 edges have passed since the edge that accepted it.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         cnt_m = '0;
      end
      ev = 1'b0;
      if (q.size() > 0) ev = (cyc - q[0].acc) >= (L - 1);
      mr = !flush && ((q.size() < L) || out_ready);
      chk("out_valid", out_valid, ev);
      if (ev && out_valid) begin
         chk("out_data", out_data, q[0].d);
         chk("out_tag", out_tag, q[0].t);
         chk("out_last", out_last, q[0].l);
      end
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, mr);
      chk("out_count", out_count, cnt_m);
      if (!rst) begin
         if (ev && out_ready) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 1'b1;
         end
         if (flush) q.delete();
         else if (in_valid && mr)
            q.push_back('{d: m_subword(in_data, in_rot), t: in_tag, l: in_last, acc: cyc + 1});
      end
   end

   // All tasks start and end one time unit after a rising edge.
   task automatic kat(input string nm, input logic [31:0] d, input logic rot, input logic [31:0] want);
      int e;
      in_valid  = 1'b1;
      in_data   = d;
      in_rot    = rot;
      in_tag    = 2'd3;
      in_last   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (e = 0; e < 10; e++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk({nm, "_latency"}, e, L - 1);
      chk({nm, "_data"}, out_data, want);
      @(posedge clk); #1;
   endtask

   task automatic set_word(input int idx, input int n);
      in_data = {8'(idx), 8'hA5, 8'(idx * 3), 8'h3C};
      in_rot  = idx[0];
      in_tag  = TW'(idx);
      in_last = (idx == n - 1);
   endtask

   task automatic stream(input int n, input int hold, output int acc_hold);
      int  idx, c;
      logic acc;
      idx = 0;
      c = 0;
      acc_hold = 0;
      in_valid = 1'b1;
      set_word(0, n);
      out_ready = (hold == 0);
      while (idx < n && c < 100) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            if (c < hold) acc_hold++;
            idx++;
         end
         c++;
         if (idx < n) set_word(idx, n);
         else in_valid = 1'b0;
         out_ready = (c >= hold);
      end
      chk("stream_done", idx, n);
   endtask

   task automatic drain();
      int c;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("drain_idle", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic flush_full(input logic or_flush);
      int c;
      logic [CW-1:0] cnt_before;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      c = 0;
      set_word(c, 100);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!in_ready) break;
         @(posedge clk); #1;
         c++;
         set_word(c, 100);
      end
      chk("flush_full_busy", busy, 1'b1);
      @(posedge clk); #1;
      flush = 1'b1;
      out_ready = or_flush;
      cnt_before = cnt_m;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_busy", busy, 1'b0);
      chk("flush_count", out_count, cnt_before + CW'(or_flush));
   endtask

   initial begin
      int ah;
      int sent, guard;
      logic acc;
      build_sbox();
      chk("model_kat0", m_subword(32'h00010253, 1'b0), 32'h637C77ED);
      chk("model_kat1", m_subword(32'h09CF4F3C, 1'b1), 32'h8A84EB01);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rot = 1'b0;
      in_tag = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset in the middle of traffic
      stream(3, 0, ah);
      in_valid = 1'b1;
      set_word(7, 8);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", out_count, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_last", out_last, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Known answers; 09 CF 4F 3C maps bytewise to 01 8A 84 EB
      kat("kat_00010253", 32'h00010253, 1'b0, 32'h637C77ED);
      kat("kat_ffffffff", 32'hFFFFFFFF, 1'b0, 32'h16161616);
      kat("kat_rot", 32'h09CF4F3C, 1'b1, 32'h8A84EB01);
      kat("kat_norot", 32'h09CF4F3C, 1'b0, 32'h018A84EB);

      // Backpressure: 8 back-to-back words, consumer stalled for 5 cycles
      do_reset();
      stream(8, 5, ah);
      chk("bp_accepted_while_stalled", ah, L);
      drain();
      chk("bp_count", out_count, 8);

      // Flush a full pipe, with and without a handoff in the flush cycle
      flush_full(1'b0);
      kat("kat_after_flush", 32'h00010253, 1'b0, 32'h637C77ED);
      flush_full(1'b1);
      drain();

      // Random traffic with 50% consumer readiness
      sent = 0;
      guard = 0;
      acc = 1'b0;
      in_valid = 1'b0;
      while (sent < 10000 && guard < 60000) begin
         if (!in_valid || acc) begin
            if ($urandom_range(9) != 0) begin
               in_valid = 1'b1;
               in_data  = $urandom;
               in_rot   = 1'($urandom);
               in_tag   = TW'($urandom);
               in_last  = 1'($urandom);
            end else in_valid = 1'b0;
         end
         out_ready = 1'($urandom);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) sent++;
         @(posedge clk); #1;
         guard++;
      end
      chk("random_sent", sent, 10000);
      drain();
      chk("final_queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
